// File: rtl/dmem_pkg.sv
// ---------------------------------------------------------------------------
// dmem_pkg
// Shared types and constants for the data-memory arbiter slice.
//   state_e  : arbiter owner state (idle, CPU, aux, aux under burst lock)
//   owner_e  : round-robin "last winner" encoding (CPU=0, AUX=1)
//   IO_*_BIT : address bits used to decode the memory-mapped I/O window
//   LEDR_W / HEX_W : widths of the LED and HEX display registers
// ---------------------------------------------------------------------------
package dmem_pkg;

   typedef enum logic [1:0] {
      S_IDLE     = 2'd0,
      S_CPU      = 2'd1,
      S_AUX      = 2'd2,
      S_AUX_LOCK = 2'd3
   } state_e;

   typedef enum logic {
      OWNER_CPU = 1'b0,
      OWNER_AUX = 1'b1
   } owner_e;

   localparam int IO_BASE_BIT = 8;
   localparam int IO_LEDS_BIT = 2;
   localparam int IO_HEX_BIT  = 3;

   localparam int LEDR_W = 10;
   localparam int HEX_W  = 24;

endpackage

// File: rtl/dmem_io_regs.sv
// ---------------------------------------------------------------------------
// dmem_io_regs
// Memory-mapped I/O registers behind the arbiter: LEDR and hex_digits,
// written from the granted access and optionally read back.
// Build option: define IO_READBACK_EN to make I/O reads return register
// contents; without it I/O reads return zero (writes are unaffected).
// Ports:
//   clk, reset   : clock, asynchronous active-low reset
//   we_i         : granted write strobe (already qualified by the grant)
//   io_bit_i     : address is in the I/O window
//   leds_bit_i   : address selects LEDR
//   hex_bit_i    : address selects hex_digits
//   wdata_i      : low write-data bits of the granted access
//   rdata_o      : I/O read data for the granted access
//   ledr_o/hex_o : current register contents
// ---------------------------------------------------------------------------
module dmem_io_regs
   import dmem_pkg::*;
#(
   parameter int DW = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we_i,
   input  logic              io_bit_i,
   input  logic              leds_bit_i,
   input  logic              hex_bit_i,
   input  logic [HEX_W-1:0]  wdata_i,
   output logic [DW-1:0]     rdata_o,
   output logic [LEDR_W-1:0] ledr_o,
   output logic [HEX_W-1:0]  hex_o
);

   logic [LEDR_W-1:0] ledr_q;
   logic [HEX_W-1:0]  hex_q;
   logic              io_we;

   assign io_we = we_i & io_bit_i;

   // Both select bits set (0x10C) writes both registers in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ledr_q <= '0;
         hex_q  <= '0;
      end else begin
         if (io_we && leds_bit_i) ledr_q <= wdata_i[LEDR_W-1:0];
         if (io_we && hex_bit_i)  hex_q  <= wdata_i;
      end
   end

`ifdef IO_READBACK_EN
   // HEX wins when both select bits are set.
   always_comb begin
      rdata_o = '0;
      if (hex_bit_i)       rdata_o = DW'(hex_q);
      else if (leds_bit_i) rdata_o = DW'(ledr_q);
   end
`else
   assign rdata_o = '0;
`endif

   assign ledr_o = ledr_q;
   assign hex_o  = hex_q;

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares the single data-RAM port and the I/O registers between the CPU
// (port C) and an auxiliary master (port A). Round-robin arbitration with a
// bounded burst lock for port A; grants and RAM accesses complete in the
// same cycle (RAM reads are combinational).
// Build option: IO_READBACK_EN (see dmem_io_regs) enables I/O readback.
// Ports:
//   clk, reset               : clock, asynchronous active-low reset
//   c_req/c_we/c_addr/c_wdata: CPU request and payload
//   c_gnt/c_rdata/cpu_stall  : CPU grant, read data, stall (req & !gnt)
//   a_req/a_we/a_lock/a_addr/a_wdata : aux request, payload, lock request
//   a_gnt/a_rdata            : aux grant and read data
//   mem_we/mem_addr/mem_wdata/mem_rdata : RAM port
//   LEDR, hex_digits         : I/O register outputs
// ---------------------------------------------------------------------------
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int MAX_LOCK = 8,
   parameter int AW       = 32,
   parameter int DW       = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [AW-1:0]     c_addr,
   input  logic [DW-1:0]     c_wdata,
   output logic              c_gnt,
   output logic [DW-1:0]     c_rdata,
   output logic              cpu_stall,
   input  logic              a_req,
   input  logic              a_we,
   input  logic              a_lock,
   input  logic [AW-1:0]     a_addr,
   input  logic [DW-1:0]     a_wdata,
   output logic              a_gnt,
   output logic [DW-1:0]     a_rdata,
   output logic              mem_we,
   output logic [AW-1:0]     mem_addr,
   output logic [DW-1:0]     mem_wdata,
   input  logic [DW-1:0]     mem_rdata,
   output logic [LEDR_W-1:0] LEDR,
   output logic [HEX_W-1:0]  hex_digits
);

   localparam int             CW      = $clog2(MAX_LOCK + 1);
   localparam logic [CW-1:0]  MAX_CNT = CW'(MAX_LOCK);

   state_e         state_q, state_d;
   owner_e         last_q, last_d;
   logic [CW-1:0]  lock_cnt_q, lock_cnt_d;

   logic           c_win, a_win, lock_hold;
   logic           g_we, is_io;
   logic [AW-1:0]  g_addr;
   logic [DW-1:0]  g_wdata, io_rdata, g_rdata;

   // A keeps the bus while it asks to, unless C has waited MAX_LOCK grants.
   assign lock_hold = (state_q == S_AUX_LOCK) && a_req && a_lock &&
                      ((lock_cnt_q < MAX_CNT) || !c_req);

   // NOTE: every combinational output is given a default before any branch,
   // so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      c_win = 1'b0;
      a_win = 1'b0;
      // Grants are gated by reset so nothing is granted, and nothing
      // written, from the instant reset is asserted.
      if (reset) begin
         if (lock_hold) begin
            a_win = 1'b1;
         end else if (c_req && a_req) begin
            if (last_q == OWNER_AUX) c_win = 1'b1;
            else                     a_win = 1'b1;
         end else if (c_req) begin
            c_win = 1'b1;
         end else if (a_req) begin
            a_win = 1'b1;
         end
      end
   end

   always_comb begin
      g_we    = 1'b0;
      g_addr  = '0;
      g_wdata = '0;
      if (c_win) begin
         g_we    = c_we;
         g_addr  = c_addr;
         g_wdata = c_wdata;
      end else if (a_win) begin
         g_we    = a_we;
         g_addr  = a_addr;
         g_wdata = a_wdata;
      end
   end

   // The lock counter counts A grants taken under a_lock while C waits,
   // so the forced release hands C the bus after exactly MAX_LOCK stalls.
   always_comb begin
      state_d    = S_IDLE;
      last_d     = last_q;
      lock_cnt_d = '0;
      if (c_win) begin
         state_d = S_CPU;
         last_d  = OWNER_CPU;
      end else if (a_win) begin
         state_d = a_lock ? S_AUX_LOCK : S_AUX;
         last_d  = OWNER_AUX;
         if (a_lock) begin
            lock_cnt_d = lock_cnt_q;
            if (c_req && (lock_cnt_q < MAX_CNT)) lock_cnt_d = lock_cnt_q + 1'b1;
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of the others.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         last_q     <= OWNER_AUX;
         lock_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         last_q     <= last_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   assign is_io = g_addr[IO_BASE_BIT];

   dmem_io_regs #(
      .DW(DW)
   ) u_io_regs (
      .clk        (clk),
      .reset      (reset),
      .we_i       (g_we),
      .io_bit_i   (is_io),
      .leds_bit_i (g_addr[IO_LEDS_BIT]),
      .hex_bit_i  (g_addr[IO_HEX_BIT]),
      .wdata_i    (g_wdata[HEX_W-1:0]),
      .rdata_o    (io_rdata),
      .ledr_o     (LEDR),
      .hex_o      (hex_digits)
   );

   assign g_rdata   = is_io ? io_rdata : mem_rdata;

   assign c_gnt     = c_win;
   assign a_gnt     = a_win;
   assign cpu_stall = c_req & ~c_win;
   assign c_rdata   = c_win ? g_rdata : '0;
   assign a_rdata   = a_win ? g_rdata : '0;

   assign mem_we    = g_we & ~is_io;
   assign mem_addr  = g_addr;
   assign mem_wdata = g_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter. Each driven cycle pushes its
// expected bus response to a scoreboard queue; the response is popped and
// compared on the falling edge. Register contents are checked directly.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        c_req, c_we, a_req, a_we, a_lock;
   logic [31:0] c_addr, c_wdata, a_addr, a_wdata;
   logic        c_gnt, a_gnt, cpu_stall, mem_we;
   logic [31:0] c_rdata, a_rdata, mem_addr, mem_wdata, mem_rdata;
   logic [9:0]  LEDR;
   logic [23:0] hex_digits;

`ifdef IO_READBACK_EN
   localparam bit READBACK = 1'b1;
`else
   localparam bit READBACK = 1'b0;
`endif

   typedef struct {
      string       tag;
      logic        c_gnt, a_gnt, stall, mem_we;
      logic [31:0] mem_addr, mem_wdata, c_rdata, a_rdata;
   } exp_t;

   exp_t sb[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] ram_rd(input logic [31:0] a);
      return a ^ 32'hA5A5_0000;
   endfunction

   assign mem_rdata = ram_rd(mem_addr);

   dmem_arbiter #(.MAX_LOCK(8), .AW(32), .DW(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .c_req      (c_req),
      .c_we       (c_we),
      .c_addr     (c_addr),
      .c_wdata    (c_wdata),
      .c_gnt      (c_gnt),
      .c_rdata    (c_rdata),
      .cpu_stall  (cpu_stall),
      .a_req      (a_req),
      .a_we       (a_we),
      .a_lock     (a_lock),
      .a_addr     (a_addr),
      .a_wdata    (a_wdata),
      .a_gnt      (a_gnt),
      .a_rdata    (a_rdata),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .LEDR       (LEDR),
      .hex_digits (hex_digits)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
   endtask

   task automatic compare_front();
      exp_t e;
      if (sb.size() == 0) begin
         check("scoreboard_empty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      check({e.tag, ".c_gnt"},     32'(c_gnt),     32'(e.c_gnt));
      check({e.tag, ".a_gnt"},     32'(a_gnt),     32'(e.a_gnt));
      check({e.tag, ".cpu_stall"}, 32'(cpu_stall), 32'(e.stall));
      check({e.tag, ".mem_we"},    32'(mem_we),    32'(e.mem_we));
      check({e.tag, ".mem_addr"},  mem_addr,       e.mem_addr);
      check({e.tag, ".mem_wdata"}, mem_wdata,      e.mem_wdata);
      check({e.tag, ".c_rdata"},   c_rdata,        e.c_rdata);
      check({e.tag, ".a_rdata"},   a_rdata,        e.a_rdata);
   endtask

   // win: 0 = no grant, 1 = C, 2 = A. io_val is the expected I/O read data.
   task automatic cyc(input string tag,
                      input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                      input logic ar, input logic aw, input logic al,
                      input logic [31:0] aa, input logic [31:0] ad,
                      input int win, input logic [31:0] io_val);
      exp_t e;
      c_req = cr; c_we = cw; c_addr = ca; c_wdata = cd;
      a_req = ar; a_we = aw; a_lock = al; a_addr = aa; a_wdata = ad;
      e.tag       = tag;
      e.c_gnt     = (win == 1);
      e.a_gnt     = (win == 2);
      e.stall     = cr && (win != 1);
      e.mem_we    = 1'b0;
      e.mem_addr  = '0;
      e.mem_wdata = '0;
      e.c_rdata   = '0;
      e.a_rdata   = '0;
      if (win == 1) begin
         e.mem_we    = cw && !ca[8];
         e.mem_addr  = ca;
         e.mem_wdata = cd;
         e.c_rdata   = ca[8] ? io_val : ram_rd(ca);
      end else if (win == 2) begin
         e.mem_we    = aw && !aa[8];
         e.mem_addr  = aa;
         e.mem_wdata = ad;
         e.a_rdata   = aa[8] ? io_val : ram_rd(aa);
      end
      sb.push_back(e);
      @(negedge clk);
      compare_front();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      c_req = 0; c_we = 0; c_addr = '0; c_wdata = '0;
      a_req = 0; a_we = 0; a_lock = 0; a_addr = '0; a_wdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      reset = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      idle_inputs();
      @(posedge clk);
      #1;

      // Requests during reset must not be granted.
      cyc("in_reset", 1, 1, 32'h20, 32'h5A, 1, 1, 0, 32'h30, 32'h77, 0, 0);
      check("rst.LEDR", 32'(LEDR), 32'h0);
      check("rst.hex",  32'(hex_digits), 32'h0);
      reset = 1'b1;

      // C write alone, same-cycle grant.
      cyc("c_wr", 1, 1, 32'h20, 32'h5A, 0, 0, 0, 0, 0, 1, 0);

      // Round-robin after a fresh reset: C first (last=AUX), then alternate.
      do_reset();
      cyc("rr0", 1, 0, 32'h40, 0, 1, 0, 0, 32'h80, 0, 1, 0);
      cyc("rr1", 1, 0, 32'h40, 0, 1, 0, 0, 32'h80, 0, 2, 0);
      cyc("rr2", 1, 0, 32'h40, 0, 1, 0, 0, 32'h80, 0, 1, 0);

      // A bursts under lock while C waits: 8 A grants, 1 forced C grant,
      // then A re-locks.
      for (int i = 0; i < 8; i++)
         cyc($sformatf("lock%0d", i), 1, 0, 32'h44, 0,
             1, 1, 1, 32'h200 + 32'(i * 4), 32'(i), 2, 0);
      cyc("release", 1, 0, 32'h44, 0, 1, 1, 1, 32'h220, 32'h8, 1, 0);
      cyc("relock",  1, 0, 32'h48, 0, 1, 1, 1, 32'h224, 32'h9, 2, 0);
      cyc("idle",    0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // I/O writes: never reach RAM.
      cyc("led_wr", 1, 1, 32'h104, 32'h3FF, 0, 0, 0, 0, 0, 1, 0);
      check("led_wr.LEDR", 32'(LEDR), 32'h3FF);
      cyc("hex_wr", 1, 1, 32'h108, 32'hABCDEF, 0, 0, 0, 0, 0, 1, 0);
      check("hex_wr.hex", 32'(hex_digits), 32'hABCDEF);
      check("hex_wr.LEDR", 32'(LEDR), 32'h3FF);
      cyc("both_wr", 0, 0, 0, 0, 1, 1, 0, 32'h10C, 32'h1, 2, 0);
      check("both_wr.LEDR", 32'(LEDR), 32'h001);
      check("both_wr.hex",  32'(hex_digits), 32'h000001);

      // I/O readback (zero without the build option).
      cyc("led_155", 1, 1, 32'h104, 32'h155, 0, 0, 0, 0, 0, 1, 0);
      cyc("rd_led",  1, 0, 32'h104, 0, 0, 0, 0, 0, 0, 1, READBACK ? 32'h155 : 32'h0);
      cyc("rd_hex",  1, 0, 32'h108, 0, 0, 0, 0, 0, 0, 1, READBACK ? 32'h1 : 32'h0);
      cyc("rd_both", 1, 0, 32'h10C, 0, 0, 0, 0, 0, 0, 1, READBACK ? 32'h1 : 32'h0);
      cyc("a_rd_led", 0, 0, 0, 0, 1, 0, 0, 32'h104, 0, 2, READBACK ? 32'h155 : 32'h0);
      cyc("a_rd_ram", 0, 0, 0, 0, 1, 0, 0, 32'h64, 0, 2, 0);

      // Reset during A lock cycle 3.
      cyc("alk0", 0, 0, 0, 0, 1, 1, 1, 32'h104, 32'h011, 2, 0);
      check("alk0.LEDR", 32'(LEDR), 32'h011);
      cyc("alk1", 0, 0, 0, 0, 1, 1, 1, 32'h104, 32'h022, 2, 0);
      check("alk1.LEDR", 32'(LEDR), 32'h022);
      a_req = 1; a_we = 1; a_lock = 1; a_addr = 32'h104; a_wdata = 32'h033;
      #1;
      check("alk2.a_gnt_pre", 32'(a_gnt), 32'h1);
      reset = 1'b0;
      #1;
      check("rst_mid.a_gnt",  32'(a_gnt), 32'h0);
      check("rst_mid.mem_we", 32'(mem_we), 32'h0);
      check("rst_mid.LEDR",   32'(LEDR), 32'h0);
      check("rst_mid.hex",    32'(hex_digits), 32'h0);
      @(posedge clk);
      #1;
      check("rst_hold.LEDR",  32'(LEDR), 32'h0);
      idle_inputs();
      reset = 1'b1;
      cyc("post_rst", 1, 0, 32'h50, 0, 1, 1, 1, 32'h104, 32'h044, 1, 0);
      check("post_rst.LEDR", 32'(LEDR), 32'h0);

      idle_inputs();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-RAM port and the memory-mapped I/O registers between two requesters: port C (the riscvmono CPU) and port A (an auxiliary master such as a loader or debug/DMA engine).
- Arbitrates round-robin, with a bounded burst lock for port A.
- Decodes the I/O window and owns the LEDR and HEX registers.
- Sits between the requesters and ram; RAM reads are combinational, so granted accesses complete in the same cycle.

Parameters:
- MAX_LOCK, 8: maximum consecutive cycles port A may hold the bus under a_lock while port C is requesting.
- AW, 32: address width.
- DW, 32: data width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- c_req  in  1  CPU access request.
- c_we  in  1  CPU write enable.
- c_addr  in  AW  CPU byte address.
- c_wdata  in  DW  CPU write data.
- c_gnt  out  1  CPU access granted this cycle.
- c_rdata  out  DW  CPU read data, valid when c_gnt.
- cpu_stall  out  1  c_req & !c_gnt.
- a_req  in  1  aux access request.
- a_we  in  1  aux write enable.
- a_lock  in  1  aux requests to keep the bus next cycle.
- a_addr  in  AW  aux byte address.
- a_wdata  in  DW  aux write data.
- a_gnt  out  1  aux access granted this cycle.
- a_rdata  out  DW  aux read data, valid when a_gnt.
- mem_we  out  1  RAM write enable.
- mem_addr  out  AW  RAM address.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM combinational read data.
- LEDR  out  10  LED register.
- hex_digits  out  24  HEX display register.

Behaviour:
- Reset (reset=0, async):
  - State IDLE, last=AUX, lock_cnt=0.
  - LEDR=0, hex_digits=0.
  - c_gnt=a_gnt=0; mem_we=0; mem_addr=0; mem_wdata=0.
- Grants are combinational from req, state, last and lock_cnt. At most one grant per cycle.
- A requester holds req and its payload stable until it sees gnt. The access completes in the gnt cycle, with zero added latency.
- States: IDLE, CPU, AUX, AUX_LOCK. State is registered on the granted owner.
- Arbitration per cycle:
  - AUX_LOCK with a_req & a_lock & (lock_cnt < MAX_LOCK or !c_req) -> grant A.
  - Otherwise, only one requester -> grant it.
  - Otherwise, both requesting -> grant the one != last.
  - Otherwise (no requests) -> no grant; next state IDLE.
- Next state after an A grant with a_lock=1 is AUX_LOCK. Any other A grant -> AUX. A C grant -> CPU.
- last updates to the winner on every grant; it holds when there is no grant.
- lock_cnt:
  - Increments on each A grant in AUX_LOCK while c_req=1, saturating at MAX_LOCK.
  - Clears on any C grant, on an idle cycle, or when a_lock=0.
- Forced release: when lock_cnt==MAX_LOCK and c_req=1, C is granted for exactly one cycle, then normal arbitration resumes. A may re-lock after that cycle.
- Address decode on the granted address:
  - isIO = addr[8].
  - LEDS selected by addr[2] (0x104); HEX selected by addr[3] (0x108).
  - Both bits set (0x10C) writes both registers.
- mem_we = granted & we & !isIO. mem_addr and mem_wdata come from the winner, and are 0 when there is no grant.
- IO writes are registered on the clk edge in the grant cycle:
  - LEDR <= wdata[9:0].
  - hex_digits <= wdata[23:0].
- Read data:
  - The granted port's rdata is mem_rdata for a RAM address.
  - For an IO address, rdata follows the optional feature below.
  - The non-granted port's rdata is 0.
- Reset asserted mid-burst aborts the lock immediately; no partial write occurs after reset is asserted.

Optional Feature:
- Macro: IO_READBACK_EN.
- Defined: an IO read returns {22'b0, LEDR} when addr[2], and {8'b0, hex_digits} when addr[3]. If both bits are set, the HEX read takes priority.
- Undefined: IO reads return 0. IO writes are unaffected.

Decomposition:
- Package dmem_pkg holds:
  - The state enum (IDLE, CPU, AUX, AUX_LOCK).
  - Owner encoding (CPU=0, AUX=1).
  - IO_BASE_BIT=8, IO_LEDS_BIT=2, IO_HEX_BIT=3.
  - LEDR_W=10, HEX_W=24.
- One sub-module, dmem_io_regs: the decode plus the LEDR/hex_digits registers and readback mux. The arbiter FSM stays in the top module.

Test Plan:
- Reset release, C writes 0x5A to 0x20 with A idle -> c_gnt=1 same cycle, mem_we=1, mem_addr=0x20, mem_wdata=0x5A, cpu_stall=0.
- C and A both request in the first cycle after reset -> C granted (last=AUX). Repeating both next cycle -> A granted; the grants alternate.
- A locks (a_lock=1) with C requesting continuously, MAX_LOCK=8 -> A granted 8 consecutive cycles, then C granted 1 cycle, cpu_stall=1 for exactly 8 cycles.
- C writes 0x3FF to 0x104, then 0xABCDEF to 0x108 -> LEDR=0x3FF, hex_digits=0xABCDEF, mem_we=0 both cycles. A write of 0x1 to 0x10C -> LEDR=0x001, hex_digits=0x000001.
- With IO_READBACK_EN, C reads 0x104 after LEDR=0x155 -> c_rdata=0x00000155. Without the macro -> c_rdata=0.
- Reset pulled low during A lock cycle 3 -> a_gnt=0, LEDR=0, hex_digits=0 immediately. After release, state is IDLE and a C request is granted first.
